pipe_id_ctrl: RTL and testbench

Instruction-decode control unit for the five-stage pipelined computer: the producer of the 4-bit `aluc` code and operand-select controls consumed by the EX-stage ALU. It decodes the IF/ID instruction and computes forwarding selects, load-use stall and PC source. It also owns the ID/EX, EX/MEM and MEM/WB control-field pipeline registers, so it tracks in-flight destinations itself.

---
 rtl/mips_pkg.sv | 65 ++++++
 rtl/pipe_fwd_unit.sv | 36 +++
 rtl/pipe_id_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_id_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the five-stage pipeline: opcodes, functs, ALU codes,
// PC-source and forwarding selects, and the ID/EX control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JR, PC_JUMP} pcsrc_e;
  typedef enum logic [1:0] {FWD_RF, FWD_EX_ALU, FWD_MEM_ALU, FWD_MEM_LOAD} fwd_e;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       jal;
    logic       aluimm;
    logic       shift;
    logic [3:0] aluc;
    logic [4:0] rn;
  } idex_t;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic [4:0] rn;
  } exmem_t;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
  } memwb_t;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Forwarding select and load-use hazard for one ID-stage source register.
// Purely combinational; EX-stage ALU results take priority over MEM.
module pipe_fwd_unit
  import mips_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       src_used_i,
  input  logic       ewreg_i,
  input  logic       em2reg_i,
  input  logic [4:0] ern_i,
  input  logic       mwreg_i,
  input  logic       mm2reg_i,
  input  logic [4:0] mrn_i,
  output logic [1:0] fwd_o,
  output logic       stall_o
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = ewreg_i & (ern_i != 5'd0) & (ern_i == src_i);
  assign mem_hit = mwreg_i & (mrn_i != 5'd0) & (mrn_i == src_i);

  always_comb begin
    fwd_o = FWD_RF;
    // A load in EX has no data yet; it is caught by the stall, then by MEM next cycle.
    if (ex_hit && !em2reg_i) begin
      fwd_o = FWD_EX_ALU;
    end else if (mem_hit) begin
      fwd_o = mm2reg_i ? FWD_MEM_LOAD : FWD_MEM_ALU;
    end
  end

  assign stall_o = src_used_i & ex_hit & em2reg_i;

endmodule

// File: rtl/pipe_id_ctrl.sv
// ID-stage control: decodes IF/ID, drives forwarding/stall/PC select, and
// carries control fields through ID/EX, EX/MEM, MEM/WB (1/2/3 cycles later).
module pipe_id_ctrl
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] inst,
  input  logic        rsrtequ,
  output logic        wpcir,
  output logic [1:0]  pcsource,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        regrt,
  output logic        sext,
  output logic [3:0]  ealuc,
  output logic        ealuimm,
  output logic        eshift,
  output logic        ejal,
  output logic        ewreg,
  output logic        em2reg,
  output logic        ewmem,
  output logic [4:0]  ern,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        mwmem,
  output logic [4:0]  mrn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [4:0]  wrn
);

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  logic       unused_sa;
  logic       writes, use_rs, use_rt;
  logic       stall_a, stall_b, stall;
  idex_t      dec, idex_d, idex_q;
  exmem_t     exmem_d, exmem_q;
  memwb_t     memwb_d, memwb_q;

  assign op        = inst[31:26];
  assign rs        = inst[25:21];
  assign rt        = inst[20:16];
  assign rd        = inst[15:11];
  assign fn        = inst[5:0];
  assign unused_sa = ^inst[10:6];

  always_comb begin
    dec      = '0;
    dec.aluc = ALUC_ADD;
    writes   = 1'b0;
    regrt    = 1'b0;
    sext     = 1'b0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    pcsource = PC_SEQ;
    case (op)
      OP_RTYPE: begin
        writes = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
        case (fn)
          FN_ADD: dec.aluc = ALUC_ADD;
          FN_SUB: dec.aluc = ALUC_SUB;
          FN_AND: dec.aluc = ALUC_AND;
          FN_OR:  dec.aluc = ALUC_OR;
          FN_XOR: dec.aluc = ALUC_XOR;
          FN_SLL: begin dec.aluc = ALUC_SLL; dec.shift = 1'b1; use_rs = 1'b0; end
          FN_SRL: begin dec.aluc = ALUC_SRL; dec.shift = 1'b1; use_rs = 1'b0; end
          FN_SRA: begin dec.aluc = ALUC_SRA; dec.shift = 1'b1; use_rs = 1'b0; end
          FN_JR:  begin writes = 1'b0; pcsource = PC_JR; end
          default: begin writes = 1'b0; use_rs = 1'b0; use_rt = 1'b0; end
        endcase
      end
      OP_ADDI: begin writes = 1'b1; dec.aluimm = 1'b1; regrt = 1'b1; sext = 1'b1; use_rs = 1'b1; end
      OP_ANDI: begin writes = 1'b1; dec.aluimm = 1'b1; regrt = 1'b1; use_rs = 1'b1; dec.aluc = ALUC_AND; end
      OP_ORI:  begin writes = 1'b1; dec.aluimm = 1'b1; regrt = 1'b1; use_rs = 1'b1; dec.aluc = ALUC_OR; end
      OP_XORI: begin writes = 1'b1; dec.aluimm = 1'b1; regrt = 1'b1; use_rs = 1'b1; dec.aluc = ALUC_XOR; end
      OP_LUI:  begin writes = 1'b1; dec.aluimm = 1'b1; regrt = 1'b1; dec.aluc = ALUC_LUI; end
      OP_LW: begin
        writes = 1'b1; dec.m2reg = 1'b1; dec.aluimm = 1'b1;
        regrt = 1'b1; sext = 1'b1; use_rs = 1'b1;
      end
      OP_SW: begin
        dec.wmem = 1'b1; dec.aluimm = 1'b1; regrt = 1'b1;
        sext = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      OP_BEQ: begin
        dec.aluc = ALUC_SUB; regrt = 1'b1; sext = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
        if (rsrtequ) pcsource = PC_BRANCH;
      end
      OP_BNE: begin
        dec.aluc = ALUC_SUB; regrt = 1'b1; sext = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
        if (!rsrtequ) pcsource = PC_BRANCH;
      end
      OP_J:   pcsource = PC_JUMP;
      OP_JAL: begin writes = 1'b1; dec.jal = 1'b1; pcsource = PC_JUMP; end
      default: ;
    endcase
    dec.rn   = dec.jal ? 5'd31 : (regrt ? rt : rd);
    // r0 is hard-wired zero, so a write to it is dropped here rather than in WB.
    dec.wreg = writes & (dec.rn != 5'd0);
  end

  pipe_fwd_unit u_fwd_a (
    .src_i     (rs),
    .src_used_i(use_rs),
    .ewreg_i   (idex_q.wreg),
    .em2reg_i  (idex_q.m2reg),
    .ern_i     (idex_q.rn),
    .mwreg_i   (exmem_q.wreg),
    .mm2reg_i  (exmem_q.m2reg),
    .mrn_i     (exmem_q.rn),
    .fwd_o     (fwda),
    .stall_o   (stall_a)
  );

  pipe_fwd_unit u_fwd_b (
    .src_i     (rt),
    .src_used_i(use_rt),
    .ewreg_i   (idex_q.wreg),
    .em2reg_i  (idex_q.m2reg),
    .ern_i     (idex_q.rn),
    .mwreg_i   (exmem_q.wreg),
    .mm2reg_i  (exmem_q.m2reg),
    .mrn_i     (exmem_q.rn),
    .fwd_o     (fwdb),
    .stall_o   (stall_b)
  );

  assign stall = stall_a | stall_b;
  assign wpcir = ~stall;

  always_comb begin
    idex_d = dec;
    if (stall) begin
      idex_d.wreg  = 1'b0;
      idex_d.m2reg = 1'b0;
      idex_d.wmem  = 1'b0;
    end
    exmem_d = '{wreg: idex_q.wreg, m2reg: idex_q.m2reg, wmem: idex_q.wmem, rn: idex_q.rn};
    memwb_d = '{wreg: exmem_q.wreg, m2reg: exmem_q.m2reg, rn: exmem_q.rn};
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ealuc   = idex_q.aluc;
  assign ealuimm = idex_q.aluimm;
  assign eshift  = idex_q.shift;
  assign ejal    = idex_q.jal;
  assign ewreg   = idex_q.wreg;
  assign em2reg  = idex_q.m2reg;
  assign ewmem   = idex_q.wmem;
  assign ern     = idex_q.rn;
  assign mwreg   = exmem_q.wreg;
  assign mm2reg  = exmem_q.m2reg;
  assign mwmem   = exmem_q.wmem;
  assign mrn     = exmem_q.rn;
  assign wwreg   = memwb_q.wreg;
  assign wm2reg  = memwb_q.m2reg;
  assign wrn     = memwb_q.rn;

endmodule

// File: tb/tb_pipe_id_ctrl.sv
// Bench for pipe_id_ctrl: directed scenarios plus a random instruction stream
// checked against a mnemonic-level pipeline model.
module tb_pipe_id_ctrl;

  typedef enum int {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA, M_JR,
                    M_ADDI, M_ANDI, M_ORI, M_XORI, M_LW, M_SW, M_BEQ, M_BNE, M_LUI,
                    M_J, M_JAL, M_UNDEF} mn_e;
  typedef struct {mn_e mn; logic [4:0] rs, rt, rd; logic [15:0] imm;} ins_t;
  typedef struct packed {
    logic bubble, wreg, m2reg, wmem, jal, aluimm, shift;
    logic [3:0] aluc;
    logic [4:0] rn;
  } rec_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] inst = '0;
  logic        rsrtequ = 1'b0;
  logic        wpcir, regrt, sext, ealuimm, eshift, ejal, ewreg, em2reg, ewmem;
  logic        mwreg, mm2reg, mwmem, wwreg, wm2reg;
  logic [1:0]  pcsource, fwda, fwdb;
  logic [3:0]  ealuc;
  logic [4:0]  ern, mrn, wrn;

  int   checks = 0;
  int   errors = 0;
  rec_t e_m, m_m, w_m;

  always #5 clock = ~clock;

  pipe_id_ctrl dut (
    .clock(clock), .resetn(resetn), .inst(inst), .rsrtequ(rsrtequ),
    .wpcir(wpcir), .pcsource(pcsource), .fwda(fwda), .fwdb(fwdb),
    .regrt(regrt), .sext(sext), .ealuc(ealuc), .ealuimm(ealuimm),
    .eshift(eshift), .ejal(ejal), .ewreg(ewreg), .em2reg(em2reg),
    .ewmem(ewmem), .ern(ern), .mwreg(mwreg), .mm2reg(mm2reg),
    .mwmem(mwmem), .mrn(mrn), .wwreg(wwreg), .wm2reg(wm2reg), .wrn(wrn)
  );

  function automatic ins_t mk(mn_e mn, int rs, int rt, int rd, int imm);
    ins_t r;
    r.mn = mn; r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd); r.imm = 16'(imm);
    return r;
  endfunction

  function automatic logic [31:0] encode(ins_t i);
    logic [5:0] op, fn;
    logic       r;
    r = 1'b0; op = 6'h00; fn = 6'h00;
    case (i.mn)
      M_ADD:  begin r = 1'b1; fn = 6'h20; end
      M_SUB:  begin r = 1'b1; fn = 6'h22; end
      M_AND:  begin r = 1'b1; fn = 6'h24; end
      M_OR:   begin r = 1'b1; fn = 6'h25; end
      M_XOR:  begin r = 1'b1; fn = 6'h26; end
      M_SLL:  begin r = 1'b1; fn = 6'h00; end
      M_SRL:  begin r = 1'b1; fn = 6'h02; end
      M_SRA:  begin r = 1'b1; fn = 6'h03; end
      M_JR:   begin r = 1'b1; fn = 6'h08; end
      M_ADDI: op = 6'h08;
      M_ANDI: op = 6'h0c;
      M_ORI:  op = 6'h0d;
      M_XORI: op = 6'h0e;
      M_LW:   op = 6'h23;
      M_SW:   op = 6'h2b;
      M_BEQ:  op = 6'h04;
      M_BNE:  op = 6'h05;
      M_LUI:  op = 6'h0f;
      M_J:    op = 6'h02;
      M_JAL:  op = 6'h03;
      default: op = 6'h3f;
    endcase
    if (r) return {6'h00, i.rs, i.rt, i.rd, i.imm[4:0], fn};
    return {op, i.rs, i.rt, i.imm};
  endfunction

  function automatic logic itype_wr(mn_e m);
    return m inside {M_ADDI, M_ANDI, M_ORI, M_XORI, M_LW, M_LUI};
  endfunction

  function automatic logic reads_rs(mn_e m);
    return m inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_JR, M_ADDI, M_ANDI,
                     M_ORI, M_XORI, M_LW, M_SW, M_BEQ, M_BNE};
  endfunction

  function automatic logic reads_rt(mn_e m);
    return m inside {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA, M_JR,
                     M_SW, M_BEQ, M_BNE};
  endfunction

  function automatic logic [3:0] aluc_of(mn_e m);
    case (m)
      M_SUB, M_BEQ, M_BNE: return 4'b0100;
      M_AND, M_ANDI:       return 4'b0001;
      M_OR, M_ORI:         return 4'b0101;
      M_XOR, M_XORI:       return 4'b0010;
      M_LUI:               return 4'b0110;
      M_SLL:               return 4'b0011;
      M_SRL:               return 4'b0111;
      M_SRA:               return 4'b1111;
      default:             return 4'b0000;
    endcase
  endfunction

  function automatic rec_t dec_rec(ins_t i);
    rec_t r;
    logic [4:0] dst;
    r = '0;
    dst = (i.mn == M_JAL) ? 5'd31 : (itype_wr(i.mn) ? i.rt : i.rd);
    r.rn     = dst;
    r.wreg   = (itype_wr(i.mn) || i.mn == M_JAL || (i.mn <= M_SRA)) && dst != 5'd0;
    r.m2reg  = (i.mn == M_LW);
    r.wmem   = (i.mn == M_SW);
    r.jal    = (i.mn == M_JAL);
    r.aluimm = itype_wr(i.mn) || i.mn == M_SW;
    r.shift  = i.mn inside {M_SLL, M_SRL, M_SRA};
    r.aluc   = aluc_of(i.mn);
    return r;
  endfunction

  function automatic logic [1:0] exp_pcs(ins_t i, logic eq);
    if ((i.mn == M_BEQ && eq) || (i.mn == M_BNE && !eq)) return 2'b01;
    if (i.mn == M_JR) return 2'b10;
    if (i.mn == M_J || i.mn == M_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [1:0] exp_fwd(logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (e_m.wreg && e_m.rn == src && !e_m.m2reg) return 2'b01;
    if (m_m.wreg && m_m.rn == src) return m_m.m2reg ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic exp_stall(ins_t i);
    if (!(e_m.wreg && e_m.m2reg) || e_m.rn == 5'd0) return 1'b0;
    return (reads_rs(i.mn) && e_m.rn == i.rs) || (reads_rt(i.mn) && e_m.rn == i.rt);
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    inst = '0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    e_m = '0; m_m = '0; w_m = '0;
  endtask

  task automatic present(input ins_t i, input logic eq);
    inst = encode(i);
    rsrtequ = eq;
    #2;
  endtask

  task automatic advance(input ins_t i);
    logic st;
    st = exp_stall(i);
    @(posedge clock);
    #1;
    w_m = m_m;
    m_m = e_m;
    if (st) begin
      e_m = '0;
      e_m.bubble = 1'b1;
    end else begin
      e_m = dec_rec(i);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({ewreg, em2reg, ewmem, ealuimm, eshift, ejal, ealuc, ern} !== 15'd0) begin
      errors++; $display("FAIL reset_e got %b exp 0", {ewreg, em2reg, ewmem, ealuimm, eshift, ejal, ealuc, ern}); end
    checks++; if ({mwreg, mm2reg, mwmem, mrn} !== 8'd0) begin
      errors++; $display("FAIL reset_m got %b exp 0", {mwreg, mm2reg, mwmem, mrn}); end
    checks++; if ({wwreg, wm2reg, wrn} !== 7'd0) begin
      errors++; $display("FAIL reset_w got %b exp 0", {wwreg, wm2reg, wrn}); end
    checks++; if (wpcir !== 1'b1) begin
      errors++; $display("FAIL reset_wpcir got %b exp 1", wpcir); end
  endtask

  task automatic test_fwd_ex_mem();
    ins_t a, b, c;
    do_reset();
    a = mk(M_ADD, 1, 2, 3, 0);
    present(a, 1'b0);
    checks++; if (fwda !== 2'b00) begin errors++; $display("FAIL fwd_add_a got %b exp 00", fwda); end
    advance(a);
    checks++; if ({ealuc, ewreg, ern} !== {4'b0000, 1'b1, 5'd3}) begin
      errors++; $display("FAIL add_e got %b exp %b", {ealuc, ewreg, ern}, {4'b0000, 1'b1, 5'd3}); end
    b = mk(M_SUB, 3, 1, 4, 0);
    present(b, 1'b0);
    checks++; if ({fwda, fwdb} !== 4'b0100) begin
      errors++; $display("FAIL fwd_sub got %b exp 0100", {fwda, fwdb}); end
    advance(b);
    checks++; if (ealuc !== 4'b0100) begin errors++; $display("FAIL sub_aluc got %b exp 0100", ealuc); end
    c = mk(M_OR, 3, 4, 8, 0);
    present(c, 1'b0);
    checks++; if ({fwda, fwdb} !== 4'b1001) begin
      errors++; $display("FAIL fwd_mem_ex got %b exp 1001", {fwda, fwdb}); end
    advance(c);
  endtask

  task automatic test_load_use();
    ins_t l, u;
    do_reset();
    l = mk(M_LW, 1, 5, 0, 0);
    present(l, 1'b0);
    advance(l);
    u = mk(M_ADD, 5, 2, 6, 0);
    present(u, 1'b0);
    checks++; if (wpcir !== 1'b0) begin errors++; $display("FAIL lu_stall got %b exp 0", wpcir); end
    advance(u);
    checks++; if ({ewreg, em2reg, ewmem} !== 3'b000) begin
      errors++; $display("FAIL lu_bubble got %b exp 000", {ewreg, em2reg, ewmem}); end
    checks++; if ({mwreg, mm2reg, mrn} !== {1'b1, 1'b1, 5'd5}) begin
      errors++; $display("FAIL lu_mem got %b exp 1100101", {mwreg, mm2reg, mrn}); end
    present(u, 1'b0);
    checks++; if ({wpcir, fwda} !== 3'b111) begin
      errors++; $display("FAIL lu_release got %b exp 111", {wpcir, fwda}); end
    advance(u);
    checks++; if ({ewreg, ern} !== {1'b1, 5'd6}) begin
      errors++; $display("FAIL lu_add_e got %b exp 100110", {ewreg, ern}); end
  endtask

  task automatic test_branch_jump();
    ins_t bq, bn, l;
    do_reset();
    bq = mk(M_BEQ, 1, 2, 0, 16'h0010);
    bn = mk(M_BNE, 1, 2, 0, 16'h0010);
    present(bq, 1'b1);
    checks++; if (pcsource !== 2'b01) begin errors++; $display("FAIL beq_taken got %b exp 01", pcsource); end
    present(bq, 1'b0);
    checks++; if (pcsource !== 2'b00) begin errors++; $display("FAIL beq_not got %b exp 00", pcsource); end
    present(bn, 1'b0);
    checks++; if (pcsource !== 2'b01) begin errors++; $display("FAIL bne_taken got %b exp 01", pcsource); end
    present(bn, 1'b1);
    checks++; if (pcsource !== 2'b00) begin errors++; $display("FAIL bne_not got %b exp 00", pcsource); end
    present(mk(M_JR, 1, 0, 0, 0), 1'b0);
    checks++; if (pcsource !== 2'b10) begin errors++; $display("FAIL jr got %b exp 10", pcsource); end
    present(mk(M_J, 3, 4, 0, 16'h0abc), 1'b0);
    checks++; if (pcsource !== 2'b11) begin errors++; $display("FAIL j got %b exp 11", pcsource); end
    l = mk(M_LW, 1, 9, 0, 4);
    present(l, 1'b0);
    advance(l);
    present(mk(M_BEQ, 9, 2, 0, 4), 1'b1);
    checks++; if ({wpcir, pcsource} !== 3'b001) begin
      errors++; $display("FAIL stall_branch got %b exp 001", {wpcir, pcsource}); end
  endtask

  task automatic test_jal_addi();
    ins_t jl, ad;
    do_reset();
    jl = mk(M_JAL, 0, 0, 0, 16'h1234);
    present(jl, 1'b0);
    checks++; if (pcsource !== 2'b11) begin errors++; $display("FAIL jal_pcs got %b exp 11", pcsource); end
    advance(jl);
    checks++; if ({ern, ejal, ewreg} !== {5'd31, 1'b1, 1'b1}) begin
      errors++; $display("FAIL jal_e got %b exp 1111111", {ern, ejal, ewreg}); end
    ad = mk(M_ADDI, 1, 0, 0, 5);
    present(ad, 1'b0);
    checks++; if (sext !== 1'b1) begin errors++; $display("FAIL addi_sext got %b exp 1", sext); end
    advance(ad);
    checks++; if (ewreg !== 1'b0) begin errors++; $display("FAIL addi_r0 got %b exp 0", ewreg); end
  endtask

  task automatic test_sra_undef();
    ins_t s, un;
    do_reset();
    s = mk(M_SRA, 0, 2, 7, 3);
    present(s, 1'b0);
    advance(s);
    checks++; if ({ealuc, eshift} !== 5'b11111) begin
      errors++; $display("FAIL sra_e got %b exp 11111", {ealuc, eshift}); end
    un = mk(M_UNDEF, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0, int'($urandom));
    present(un, 1'b1);
    checks++; if (pcsource !== 2'b00) begin errors++; $display("FAIL undef_pcs got %b exp 00", pcsource); end
    advance(un);
    checks++; if ({ewreg, ewmem} !== 2'b00) begin
      errors++; $display("FAIL undef_e got %b exp 00", {ewreg, ewmem}); end
  endtask

  task automatic test_reset_mid_stall();
    ins_t l, u;
    do_reset();
    l = mk(M_LW, 2, 7, 0, 0);
    present(l, 1'b0);
    advance(l);
    u = mk(M_SW, 3, 7, 0, 8);
    present(u, 1'b0);
    checks++; if (wpcir !== 1'b0) begin errors++; $display("FAIL rst_stall_pre got %b exp 0", wpcir); end
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    e_m = '0; m_m = '0; w_m = '0;
    checks++; if ({wpcir, ewreg, mwreg} !== 3'b100) begin
      errors++; $display("FAIL rst_stall_post got %b exp 100", {wpcir, ewreg, mwreg}); end
  endtask

  task automatic test_random();
    ins_t cur;
    logic eq, st;
    do_reset();
    cur = mk(M_ADD, 1, 2, 3, 0);
    for (int cyc = 0; cyc < 800; cyc++) begin
      eq = 1'($urandom_range(0, 1));
      present(cur, eq);
      checks++;
      if ({wpcir, pcsource, fwda, fwdb} !== {~exp_stall(cur), exp_pcs(cur, eq), exp_fwd(cur.rs), exp_fwd(cur.rt)}) begin
        errors++;
        $display("FAIL rnd_comb cyc %0d got %b exp %b", cyc, {wpcir, pcsource, fwda, fwdb},
                 {~exp_stall(cur), exp_pcs(cur, eq), exp_fwd(cur.rs), exp_fwd(cur.rt)});
      end
      if (cur.mn inside {M_ADDI, M_LW, M_SW, M_BEQ, M_BNE, M_ANDI, M_ORI, M_XORI, M_LUI}) begin
        checks++;
        if (sext !== (cur.mn inside {M_ADDI, M_LW, M_SW, M_BEQ, M_BNE})) begin
          errors++; $display("FAIL rnd_sext cyc %0d got %b", cyc, sext); end
      end
      if (itype_wr(cur.mn) || cur.mn <= M_SRA) begin
        checks++;
        if (regrt !== itype_wr(cur.mn)) begin
          errors++; $display("FAIL rnd_regrt cyc %0d got %b exp %b", cyc, regrt, itype_wr(cur.mn)); end
      end
      st = exp_stall(cur);
      advance(cur);
      checks++;
      if ({ewreg, em2reg, ewmem, mwreg, mm2reg, mwmem, wwreg, wm2reg} !==
          {e_m.wreg, e_m.m2reg, e_m.wmem, m_m.wreg, m_m.m2reg, m_m.wmem, w_m.wreg, w_m.m2reg}) begin
        errors++;
        $display("FAIL rnd_ctl cyc %0d got %b exp %b", cyc,
                 {ewreg, em2reg, ewmem, mwreg, mm2reg, mwmem, wwreg, wm2reg},
                 {e_m.wreg, e_m.m2reg, e_m.wmem, m_m.wreg, m_m.m2reg, m_m.wmem, w_m.wreg, w_m.m2reg});
      end
      if (!e_m.bubble) begin
        checks++;
        if ({ealuc, ealuimm, eshift, ejal} !== {e_m.aluc, e_m.aluimm, e_m.shift, e_m.jal}) begin
          errors++; $display("FAIL rnd_e_fields cyc %0d got %b exp %b", cyc,
                             {ealuc, ealuimm, eshift, ejal}, {e_m.aluc, e_m.aluimm, e_m.shift, e_m.jal}); end
      end
      if (e_m.wreg) begin
        checks++; if (ern !== e_m.rn) begin errors++; $display("FAIL rnd_ern cyc %0d got %0d exp %0d", cyc, ern, e_m.rn); end
      end
      if (m_m.wreg) begin
        checks++; if (mrn !== m_m.rn) begin errors++; $display("FAIL rnd_mrn cyc %0d got %0d exp %0d", cyc, mrn, m_m.rn); end
      end
      if (w_m.wreg) begin
        checks++; if (wrn !== w_m.rn) begin errors++; $display("FAIL rnd_wrn cyc %0d got %0d exp %0d", cyc, wrn, w_m.rn); end
      end
      // A stalled instruction stays in IF/ID and is presented again.
      if (!st) begin
        cur = mk(mn_e'($urandom_range(0, 19)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), int'($urandom));
        if ($urandom_range(0, 3) == 0) cur.mn = M_LW;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fwd_ex_mem();
    test_load_use();
    test_branch_jump();
    test_jal_addi();
    test_sra_undef();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
